phase_sequencer: RTL and testbench

Parametrised successor to the fixed four-phase clock-enable generator. Emits a repeating, software-programmable pattern of one-cycle enable pulses on NUM_CHANNELS channels (default: channel 0 = pc, 1 = reg, 2 = mem) over a programmable period of 1..NUM_SLOTS cycles. Adds run/halt, single-period step and stall control so the datapath can be frozen, single-stepped from a debug controller, or re-timed without re-synthesis. Sits between the board clock and the datapath register-enable inputs.

---
 rtl/phase_sequencer.sv | 162 ++++++++++++++++
 tb/tb_phase_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Programmable multi-channel enable-pulse generator. Each cycle of a period
//   emits one slot of a software-writable schedule as one-cycle enable pulses.
//   Run/halt, single-period step and stall controls let the datapath be
//   frozen, single-stepped or re-timed at run time.
//
// Ports
//   clock         sole clock, rising edge
//   reset         asynchronous active-high reset, clears all state
//   run           level, free-run request
//   step          in HALT with run=0, starts exactly one period
//   stall         freezes sequencing (highest priority after reset)
//   sched_we      schedule write strobe
//   sched_addr    slot index to write
//   sched_wdata   channel mask for that slot
//   len_we        period-length write strobe
//   len           new period length (1..NUM_SLOTS accepted)
//   phase         registered enable pulses
//   slot          index of the slot currently shown on phase
//   period_start  high while slot 0 is shown
//   period_end    high while the last slot of the period is shown
//   busy          high while a period is being emitted
module phase_sequencer #(
   parameter int unsigned NUM_CHANNELS = 3,
   parameter int unsigned NUM_SLOTS    = 8,
   localparam int unsigned SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   localparam int unsigned LEN_W       = SLOT_W + 1,
   parameter logic [NUM_CHANNELS*NUM_SLOTS-1:0] RESET_SCHEDULE = 24'h0002A2,
   parameter int unsigned RESET_LEN    = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    step,
   input  logic                    stall,
   input  logic                    sched_we,
   input  logic [SLOT_W-1:0]       sched_addr,
   input  logic [NUM_CHANNELS-1:0] sched_wdata,
   input  logic                    len_we,
   input  logic [LEN_W-1:0]        len,
   output logic [NUM_CHANNELS-1:0] phase,
   output logic [SLOT_W-1:0]       slot,
   output logic                    period_start,
   output logic                    period_end,
   output logic                    busy
);

   typedef enum logic [1:0] {HALT, RUN, STEP} state_t;

   state_t                  state, state_n;
   logic [SLOT_W-1:0]       counter, counter_n;
   logic [LEN_W-1:0]        len_reg, active_len, active_len_n;
   logic [NUM_CHANNELS-1:0] sched [NUM_SLOTS];

   logic [NUM_CHANNELS-1:0] phase_n;
   logic [SLOT_W-1:0]       slot_n;
   logic                    start_n, end_n, busy_n;
   logic                    emit, emit_last;
   logic [SLOT_W-1:0]       emit_slot;

   // Slot 0 emission loads active_len from len_reg, so the last-slot test
   // for slot 0 must already use the pending length.
   function automatic logic slot_is_last(input logic [SLOT_W-1:0] s);
      logic [LEN_W-1:0] l;
      l = (s == '0) ? len_reg : active_len;
      return ({1'b0, s} == (l - LEN_W'(1)));
   endfunction

   // Schedule table and programmed length
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++)
            sched[i] <= RESET_SCHEDULE[i*NUM_CHANNELS +: NUM_CHANNELS];
         len_reg <= LEN_W'(RESET_LEN);
      end else begin
         if (sched_we && ({1'b0, sched_addr} < LEN_W'(NUM_SLOTS)))
            sched[sched_addr] <= sched_wdata;
         if (len_we && (len != '0) && (len <= LEN_W'(NUM_SLOTS)))
            len_reg <= len;
      end
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= HALT;
         counter      <= '0;
         active_len   <= LEN_W'(RESET_LEN);
         phase        <= '0;
         slot         <= '0;
         period_start <= 1'b0;
         period_end   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         counter      <= counter_n;
         active_len   <= active_len_n;
         phase        <= phase_n;
         slot         <= slot_n;
         period_start <= start_n;
         period_end   <= end_n;
         busy         <= busy_n;
      end
   end

   always_comb begin
      state_n      = state;
      counter_n    = counter;
      active_len_n = active_len;
      phase_n      = '0;
      slot_n       = slot;
      start_n      = 1'b0;
      end_n        = 1'b0;
      emit         = 1'b0;
      emit_slot    = counter;
      emit_last    = 1'b0;

      if (!stall) begin
         case (state)
            HALT: begin
               if (run) begin
                  state_n   = RUN;
                  emit      = 1'b1;
                  emit_slot = '0;
               end else if (step) begin
                  // A one-slot period is complete at this very edge.
                  state_n   = slot_is_last('0) ? HALT : STEP;
                  emit      = 1'b1;
                  emit_slot = '0;
               end
            end
            RUN: begin
               emit = 1'b1;
               if (slot_is_last(counter) && !run)
                  state_n = HALT;
            end
            STEP: begin
               emit = 1'b1;
               if (slot_is_last(counter))
                  state_n = run ? RUN : HALT;
            end
            default: state_n = HALT;
         endcase
      end

      if (emit) begin
         emit_last = slot_is_last(emit_slot);
         phase_n   = sched[emit_slot];
         slot_n    = emit_slot;
         start_n   = (emit_slot == '0);
         end_n     = emit_last;
         counter_n = emit_last ? '0 : emit_slot + SLOT_W'(1);
         if (emit_slot == '0)
            active_len_n = len_reg;
      end

      // busy stays up through the cycle showing the last slot, and is held
      // across a stall inside a period.
      busy_n = emit | (stall & (state != HALT));
   end

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0, step = 1'b0, stall = 1'b0;
   logic       sched_we = 1'b0;
   logic [2:0] sched_addr = '0;
   logic [2:0] sched_wdata = '0;
   logic       len_we = 1'b0;
   logic [3:0] len = '0;
   logic [2:0] phase;
   logic [2:0] slot;
   logic       period_start, period_end, busy;

   int n_checks = 0;
   int n_errors = 0;

   phase_sequencer #(.NUM_CHANNELS(3), .NUM_SLOTS(8), .RESET_SCHEDULE(24'h0002A2), .RESET_LEN(8)) dut (
      .clock(clock), .reset(reset), .run(run), .step(step), .stall(stall),
      .sched_we(sched_we), .sched_addr(sched_addr), .sched_wdata(sched_wdata),
      .len_we(len_we), .len(len), .phase(phase), .slot(slot),
      .period_start(period_start), .period_end(period_end), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0] phase;
      logic [2:0] slot;
      logic       ps;
      logic       pe;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;

   // Reference model state
   int         m_mode;   // 0 halted, 1 running, 2 stepping
   int         m_pos;    // next slot to show
   int         m_len;    // length of the period in progress
   int         m_plen;   // programmed length
   logic [2:0] m_tab [8];

   logic [2:0] pat [8] = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      logic [23:0] rs;
      rs = 24'h0002A2;
      m_mode = 0; m_pos = 0; m_len = 8; m_plen = 8;
      for (int i = 0; i < 8; i++) m_tab[i] = rs[i*3 +: 3];
      last_exp = '0;
   endtask

   // Predicts what the DUT shows after the coming edge for the inputs now applied.
   task automatic model_edge();
      exp_t e;
      bit   emit;
      e = last_exp;
      e.phase = '0; e.ps = 1'b0; e.pe = 1'b0;
      emit = 1'b0;
      if (stall) begin
         e.busy = (m_mode != 0);
      end else begin
         if (m_mode == 0) begin
            if (run) begin m_mode = 1; m_pos = 0; emit = 1'b1; end
            else if (step) begin m_mode = 2; m_pos = 0; emit = 1'b1; end
         end else begin
            emit = 1'b1;
         end
         if (emit) begin
            if (m_pos == 0) m_len = m_plen;
            e.phase = m_tab[m_pos];
            e.slot  = 3'(m_pos);
            e.ps    = (m_pos == 0);
            e.pe    = (m_pos == m_len - 1);
            if (m_pos == m_len - 1) begin
               m_pos = 0;
               if (m_mode == 1 && !run) m_mode = 0;
               else if (m_mode == 2) m_mode = run ? 1 : 0;
            end else begin
               m_pos++;
            end
         end
         e.busy = emit;
      end
      if (sched_we && int'(sched_addr) < 8) m_tab[sched_addr] = sched_wdata;
      if (len_we && len >= 1 && len <= 8) m_plen = int'(len);
      sb.push_back(e);
      last_exp = e;
   endtask

   task automatic cycle();
      exp_t e;
      model_edge();
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("phase", phase, e.phase);
         check("slot", slot, e.slot);
         check("period_start", period_start, e.ps);
         check("period_end", period_end, e.pe);
         check("busy", busy, e.busy);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_phase"}, phase, 0);
      check({tag, "_slot"}, slot, 0);
      check({tag, "_start"}, period_start, 0);
      check({tag, "_end"}, period_end, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   int busy_cnt;

   initial begin
      // Reset state
      #12;
      check_zero("reset");
      reset = 1'b0;
      model_reset();
      repeat (2) cycle();

      // Free run with the default schedule
      run = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cycle();
         check("default_pattern", phase, pat[i % 8]);
      end

      // Stall for three edges while slot 2 is shown
      repeat (3) cycle();
      check("pre_stall_slot", slot, 2);
      stall = 1'b1;
      repeat (3) cycle();
      stall = 1'b0;
      cycle();
      check("post_stall_slot", slot, 3);
      check("post_stall_phase", phase, 3'b001);
      repeat (4) cycle();

      // Drop run at slot 4: period completes, then halt
      repeat (5) cycle();
      run = 1'b0;
      repeat (3) cycle();
      check("halt_end_slot", slot, 7);
      repeat (3) cycle();

      // Single step; a second step during the period is ignored
      step = 1'b1;
      cycle();
      step = 1'b0;
      busy_cnt = int'(busy);
      for (int i = 0; i < 10; i++) begin
         step = (i == 2);
         cycle();
         busy_cnt += int'(busy);
      end
      step = 1'b0;
      check("step_busy_cycles", busy_cnt, 8);

      // Length change mid-period; invalid lengths ignored
      run = 1'b1;
      repeat (5) cycle();
      len_we = 1'b1; len = 4'd4; cycle();
      len = 4'd0; cycle();
      len = 4'd9; cycle();
      check("old_period_end", period_end, 1);
      len_we = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         check("len4_pattern", phase, pat[i % 4]);
      end

      // Schedule write at the edge showing slot 3
      repeat (3) cycle();
      sched_we = 1'b1; sched_addr = 3'd3; sched_wdata = 3'b110;
      cycle();
      check("sched_old", phase, 3'b001);
      sched_we = 1'b0;
      repeat (4) cycle();
      check("sched_new", phase, 3'b110);

      // Length 1: every emission is slot 0 with both flags
      len_we = 1'b1; len = 4'd1; cycle();
      len_we = 1'b0;
      repeat (4) cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("len1_flags", {slot, period_start, period_end}, 5'b000_1_1);
      end
      len_we = 1'b1; len = 4'd8; cycle();
      len_we = 1'b0;
      repeat (3) cycle();

      // Asynchronous reset mid-period
      #2;
      reset = 1'b1;
      #1;
      check_zero("async_reset");
      #1;
      reset = 1'b0;
      sb.delete();
      model_reset();
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("restored_pattern", phase, pat[i]);
      end
      run = 1'b0;
      repeat (2) cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
